y86_data_ram: RTL and testbench
===============================

// Module: y86_data_ram
// PURPOSE
// - Data-memory responder for the CPU load/store port (mem_read/mem_write/mem_addr/mem_data).
// - Sits beside the instruction ROM in the SOPC top and serves mrmovl/rmmovl/pushl/popl/call/ret.
// - Adds a ready handshake and a programmable access latency so the pipeline can be stall-tested.
// - Storage is a byte array; accesses are 32-bit little-endian words at any byte address.
// PARAMETERS
// - DEPTH    256  bytes of storage; must be a power of two matching the 8-bit mem_addr range.
// - LATENCY  2    cycles from request acceptance to mem_ready_o; legal range 1..15.
// PORTS
// - clk           in   1   system clock; all state changes on the rising edge.
// - rst           in   1   asynchronous, active-low reset.
// - mem_read_i    in   1   load request, held high until mem_ready_o.
// - mem_write_i   in   1   store request, held high until mem_ready_o.
// - mem_addr_i    in   8   byte address of the least significant byte of the word.
// - mem_data_i    in   32  store data.
// - mem_data_o    out  32  load data; valid in the mem_ready_o cycle and held afterwards.
// - mem_ready_o   out  1   one-cycle pulse: access complete.
// - mem_err_o     out  1   present only with Y86_DMEM_BOUNDS_EN (see CONFIGURATION).
// BEHAVIOUR
// - Reset (rst low, asynchronous): state=IDLE; counter=0; mem_data_o=0; mem_ready_o=0; mem_err_o=0.
// - Reset does not clear storage contents.
// - FSM IDLE: when mem_read_i|mem_write_i is high, latch addr, data and op, then go to BUSY.
// - Op select: write takes priority when both requests are high.
// - FSM BUSY: counter counts 1..LATENCY-1; then go to DONE. With LATENCY=1, go straight to DONE.
// - FSM DONE: mem_ready_o=1 for this cycle only.
//   - Store: commit bytes addr..addr+3 this edge.
//   - Load: drive mem_data_o with {b[a+3],b[a+2],b[a+1],b[a]}.
//   - Then return to IDLE.
// - Latency: a request first seen at edge N completes with mem_ready_o high in cycle N+LATENCY.
// - Back-to-back: IDLE needs one cycle, so the minimum request spacing is LATENCY+1 cycles.
// - Inputs are sampled only in IDLE. Changes during BUSY/DONE are ignored.
// - A request still held high in the cycle after DONE is taken as a new access; the CPU must drop it.
// - Byte index arithmetic is modulo DEPTH: a word at 0xFE uses bytes 0xFE, 0xFF, 0x00, 0x01.
// - A load never changes storage. A store never changes mem_data_o.
// - Reset mid-access: the operation is aborted, no bytes are written, and no ready pulse is issued.
// CONFIGURATION
// - Y86_DMEM_BOUNDS_EN defined:
//   - mem_err_o exists.
//   - An access with addr > DEPTH-4 completes normally in timing (ready pulse), but stores write nothing.
//   - Loads of such an address return 0.
//   - mem_err_o=1 in the same cycle as mem_ready_o; this becomes the Y86 ADR status.
// - Y86_DMEM_BOUNDS_EN undefined: mem_err_o is absent and the modulo wrap above applies.
// TESTING
// - Reset values: rst low, then high; all outputs 0 and no ready pulse while requests are low.
// - Store then load: write 0x12345678 @0x10, then read @0x10 -> mem_data_o=0x12345678.
//   - Check byte order: read @0x11 -> 0x??123456, with byte 0x14 as the top byte.
// - Latency: LATENCY=3, read asserted before edge 0 -> mem_ready_o high only in cycle 3, one cycle wide.
// - Wrap / bounds:
//   - Without the macro: write 0xAABBCCDD @0xFE; read @0x00 -> low half 0xAABB.
//   - With the macro: the same write gives mem_err_o=1 and storage is unchanged.
// - Read and write together: both high with addr 0x20, data 0xCAFEF00D -> write performed.
//   - A later read @0x20 returns 0xCAFEF00D.
// - Reset mid-store: rst low during BUSY of a write @0x30 -> no ready pulse.
//   - Read @0x30 after reset returns the old value.

Source files
------------

// File: rtl/y86_data_ram.sv
// y86_data_ram: data-memory responder for the Y86 CPU load/store port.
// Byte-array storage, 32-bit little-endian word accesses at any byte address,
// with a ready handshake and a fixed access latency of LATENCY cycles.
// Optional macro Y86_DMEM_BOUNDS_EN adds mem_err_o and suppresses wrapped
// accesses (addr > DEPTH-4) instead of letting them wrap modulo DEPTH.
module y86_data_ram #(
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [7:0]  mem_addr_i,
    input  logic [31:0] mem_data_i,
    output logic [31:0] mem_data_o,
    output logic        mem_ready_o
`ifdef Y86_DMEM_BOUNDS_EN
    ,
    output logic        mem_err_o
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(LATENCY - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  addr_q;
    logic [31:0] wdata_q;
    logic        wr_q;

    logic        accept;
    logic        commit;
    logic        ready_d;
    logic [31:0] data_d;
    logic [31:0] rdata;
    logic        oob;
    logic [7:0]  idx [4];

    logic [7:0]  mem [DEPTH];

`ifdef Y86_DMEM_BOUNDS_EN
    localparam logic [7:0] ADDR_MAX = 8'(DEPTH - 4);
    logic err_d;

    // Flag word accesses that would run past the top of storage.
    always_comb begin
        oob = (addr_q > ADDR_MAX);
    end
`else
    // Without bounds checking every address is legal and wraps modulo DEPTH.
    always_comb begin
        oob = 1'b0;
    end
`endif

    // Byte indices of the latched word (8-bit add wraps modulo DEPTH) and the assembled load word.
    always_comb begin
        for (int unsigned k = 0; k < 4; k++) begin
            idx[k] = addr_q + 8'(k);
        end
        rdata = {mem[idx[3]], mem[idx[2]], mem[idx[1]], mem[idx[0]]};
    end

    // Next-state logic: IDLE samples the request, BUSY counts latency, DONE completes the access.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        commit  = 1'b0;
        ready_d = 1'b0;
        data_d  = mem_data_o;
`ifdef Y86_DMEM_BOUNDS_EN
        err_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (mem_read_i || mem_write_i) begin
                    accept  = 1'b1;
                    cnt_d   = 4'd1;
                    state_d = (LATENCY == 1) ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (cnt_q >= CNT_LAST) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE: begin
                // Ready, load data and store commit are all registered on the edge leaving DONE,
                // so they become visible LATENCY cycles after the accepting edge.
                ready_d = 1'b1;
                cnt_d   = '0;
                state_d = IDLE;
                if (wr_q) begin
                    commit = !oob;
                end else begin
                    data_d = oob ? '0 : rdata;
                end
`ifdef Y86_DMEM_BOUNDS_EN
                err_d = oob;
`endif
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Control state, latched request and registered outputs; cleared by asynchronous reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wr_q        <= 1'b0;
            mem_data_o  <= '0;
            mem_ready_o <= 1'b0;
`ifdef Y86_DMEM_BOUNDS_EN
            mem_err_o   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_data_o  <= data_d;
            mem_ready_o <= ready_d;
`ifdef Y86_DMEM_BOUNDS_EN
            mem_err_o   <= err_d;
`endif
            if (accept) begin
                addr_q  <= mem_addr_i;
                wdata_q <= mem_data_i;
                wr_q    <= mem_write_i;
            end
        end
    end

    // Storage is not reset; a store commits its four bytes on the edge leaving DONE.
    always_ff @(posedge clk) begin
        if (commit) begin
            for (int unsigned k = 0; k < 4; k++) begin
                mem[idx[k]] <= wdata_q[8*k +: 8];
            end
        end
    end

endmodule

// File: tb/tb_y86_data_ram.sv
// tb_y86_data_ram: randomized self-checking bench for y86_data_ram.
// Reference model is a plain byte array; word accesses are assembled with
// modulo-256 indexing (or suppressed out-of-range when Y86_DMEM_BOUNDS_EN is set).
module tb_y86_data_ram;

    localparam int unsigned LAT = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_read_i = 1'b0;
    logic        mem_write_i = 1'b0;
    logic [7:0]  mem_addr_i = '0;
    logic [31:0] mem_data_i = '0;
    logic [31:0] mem_data_o;
    logic        mem_ready_o;
`ifdef Y86_DMEM_BOUNDS_EN
    logic        mem_err_o;
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    int unsigned tests = 0;
    int unsigned failed = 0;

    logic [7:0]  ref_mem [256];
    logic [31:0] ref_out = '0;

    y86_data_ram #(.DEPTH(256), .LATENCY(LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_read_i (mem_read_i),
        .mem_write_i(mem_write_i),
        .mem_addr_i (mem_addr_i),
        .mem_data_i (mem_data_i),
        .mem_data_o (mem_data_o),
        .mem_ready_o(mem_ready_o)
`ifdef Y86_DMEM_BOUNDS_EN
        ,
        .mem_err_o  (mem_err_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input logic [7:0] a);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) begin
            w[8*i +: 8] = ref_mem[(int'(a) + i) % 256];
        end
        return w;
    endfunction

    // One full access: drive the request, wait for ready (bounded), check timing and result.
    task automatic access(input logic wr, input logic rd, input logic [7:0] a, input logic [31:0] d);
        int unsigned n;
        logic seen;
        logic oob;
        oob = BOUNDS && (int'(a) > 252);
        @(negedge clk);
        mem_write_i = wr;
        mem_read_i  = rd;
        mem_addr_i  = a;
        mem_data_i  = d;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            seen = mem_ready_o;
            if (n == 1) begin
                mem_addr_i = 8'($urandom);
                mem_data_i = $urandom;
            end
        end
        mem_write_i = 1'b0;
        mem_read_i  = 1'b0;
        check("latency", 32'(n), 32'(LAT + 1));
        if (wr) begin
            if (!oob) begin
                for (int i = 0; i < 4; i++) ref_mem[(int'(a) + i) % 256] = d[8*i +: 8];
            end
        end else begin
            ref_out = oob ? 32'h0 : ref_word(a);
        end
        check(wr ? "store_data_hold" : "load_data", mem_data_o, ref_out);
`ifdef Y86_DMEM_BOUNDS_EN
        check("err", 32'(mem_err_o), 32'(oob));
`endif
        @(posedge clk);
        #1;
        check("ready_width", 32'(mem_ready_o), 32'h0);
    endtask

    initial begin
        logic [7:0]  a;
        logic [31:0] d;
        logic        w;

        #2 rst = 1'b0;
        #1;
        check("rst_ready", 32'(mem_ready_o), 32'h0);
        check("rst_data", mem_data_o, 32'h0);
`ifdef Y86_DMEM_BOUNDS_EN
        check("rst_err", 32'(mem_err_o), 32'h0);
`endif
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("idle_ready", 32'(mem_ready_o), 32'h0);
        end

        // Give every byte a known value.
        for (int i = 0; i < 64; i++) access(1'b1, 1'b0, 8'(i * 4), $urandom);

        // Directed store/load and byte order.
        access(1'b1, 1'b0, 8'h10, 32'h12345678);
        access(1'b0, 1'b1, 8'h10, 32'h0);
        check("load_0x10", mem_data_o, 32'h12345678);
        access(1'b0, 1'b1, 8'h11, 32'h0);
        check("load_0x11_low", {8'h00, mem_data_o[23:0]}, 32'h00123456);

        // Wrap / bounds at the top of storage.
        access(1'b1, 1'b0, 8'hFE, 32'hAABBCCDD);
        access(1'b0, 1'b1, 8'h00, 32'h0);
        if (!BOUNDS) check("wrap_low_half", {16'h0, mem_data_o[15:0]}, 32'h0000AABB);

        // Both requests high: write wins.
        access(1'b1, 1'b1, 8'h20, 32'hCAFEF00D);
        access(1'b0, 1'b1, 8'h20, 32'h0);
        check("rw_priority", mem_data_o, 32'hCAFEF00D);

        // Reset during BUSY of a store: no ready, no bytes written.
        @(negedge clk);
        mem_write_i = 1'b1;
        mem_addr_i  = 8'h30;
        mem_data_i  = ~ref_word(8'h30);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        ref_out = '0;
        check("abort_ready", 32'(mem_ready_o), 32'h0);
        check("abort_data", mem_data_o, 32'h0);
        @(negedge clk);
        mem_write_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < LAT + 2; i++) begin
            @(posedge clk);
            #1;
            check("abort_no_ready", 32'(mem_ready_o), 32'h0);
        end
        access(1'b0, 1'b1, 8'h30, 32'h0);

        // Randomized traffic, biased toward the wrap region.
        for (int i = 0; i < 200; i++) begin
            w = 1'($urandom_range(0, 1));
            a = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(248, 255)) : 8'($urandom);
            d = $urandom;
            access(w, w ? 1'($urandom_range(0, 1)) : 1'b1, a, d);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
